// File: rtl/cache_refill_arbiter.sv
// Round-robin refill arbiter: shares one AXI read channel between the I-cache and
// D-cache, issues one INCR line burst per grant and returns the assembled line.

module line_word_reg #(
    parameter int DATA = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            we,
    input  logic [DATA-1:0] d,
    output logic [DATA-1:0] q
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  q <= '0;
        else if (we) q <= d;
    end
endmodule

module cache_refill_arbiter #(
    parameter int WIDTH_ADD = 32,
    parameter int DATA      = 32,
    parameter int N_WORD    = 8
) (
    input  logic                   AXI_CLK,
    input  logic                   AXI_RESETn,
    input  logic                   I_REQ,
    input  logic [WIDTH_ADD-1:0]   I_ADDR,
    output logic                   I_VALID,
    input  logic                   D_REQ,
    input  logic [WIDTH_ADD-1:0]   D_ADDR,
    output logic                   D_VALID,
    output logic [DATA*N_WORD-1:0] LINE_DATA,
    output logic                   LINE_ERR,
    output logic                   AXI_ARVALID,
    input  logic                   AXI_ARREADY,
    output logic [WIDTH_ADD-1:0]   AXI_ARADDR,
    output logic [7:0]             AXI_ARLEN,
    output logic [2:0]             AXI_ARSIZE,
    output logic [1:0]             AXI_ARBURST,
    output logic [2:0]             AXI_ARPROT,
    output logic [3:0]             AXI_ARCACHE,
    input  logic                   AXI_RVALID,
    input  logic [DATA-1:0]        AXI_RDATA,
    input  logic [1:0]             AXI_RRESP,
    input  logic                   AXI_RLAST,
    output logic                   AXI_RREADY
);
    localparam int CW   = $clog2(N_WORD) + 1;
    localparam int OFFS = $clog2(N_WORD * DATA / 8);
    localparam logic [WIDTH_ADD-1:0] LINE_MASK = ~((WIDTH_ADD'(1) << OFFS) - WIDTH_ADD'(1));
    localparam logic GRANT_I = 1'b0;
    localparam logic GRANT_D = 1'b1;

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_DONE} state_t;

    typedef struct packed {
        logic                 id;
        logic [WIDTH_ADD-1:0] addr;
    } grant_t;

    state_t                       state;
    logic                         last_grant;
    logic                         gnt_id;
    logic [CW-1:0]                cnt;
    logic                         err;
    logic                         err_next;
    logic                         beat;
    grant_t                       pick;
    logic [N_WORD-1:0]            word_we;
    logic [N_WORD-1:0][DATA-1:0]  line;

    assign AXI_ARLEN   = 8'(N_WORD - 1);
    assign AXI_ARSIZE  = 3'($clog2(DATA / 8));
    assign AXI_ARBURST = 2'b01;
    assign LINE_DATA   = line;

    assign beat = (state == S_DATA) && AXI_RVALID && AXI_RREADY;

    // Overflow beats, early/late RLAST and any non-OKAY response all poison the line.
    assign err_next = err | (AXI_RRESP != 2'b00) | (cnt == CW'(N_WORD))
                    | (AXI_RLAST && (cnt != CW'(N_WORD - 1)));

    always_comb begin
        pick.id = GRANT_I;
        if (I_REQ && D_REQ) pick.id = ~last_grant;
        else if (D_REQ)     pick.id = GRANT_D;
        pick.addr = ((pick.id == GRANT_I) ? I_ADDR : D_ADDR) & LINE_MASK;
    end

    always_comb begin
        word_we = '0;
        for (int i = 0; i < N_WORD; i++)
            word_we[i] = beat && (cnt == CW'(i));
    end

    for (genvar g = 0; g < N_WORD; g++) begin : g_word
        line_word_reg #(.DATA(DATA)) u_word (
            .clk   (AXI_CLK),
            .rst_n (AXI_RESETn),
            .we    (word_we[g]),
            .d     (AXI_RDATA),
            .q     (line[g])
        );
    end

    always_ff @(posedge AXI_CLK or negedge AXI_RESETn) begin
        if (!AXI_RESETn) begin
            state       <= S_IDLE;
            last_grant  <= GRANT_D;
            gnt_id      <= GRANT_I;
            cnt         <= '0;
            err         <= 1'b0;
            AXI_ARVALID <= 1'b0;
            AXI_ARADDR  <= '0;
            AXI_ARPROT  <= 3'b000;
            AXI_ARCACHE <= 4'b0000;
            AXI_RREADY  <= 1'b0;
            I_VALID     <= 1'b0;
            D_VALID     <= 1'b0;
            LINE_ERR    <= 1'b0;
        end else begin
            I_VALID <= 1'b0;
            D_VALID <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (I_REQ || D_REQ) begin
                        gnt_id      <= pick.id;
                        last_grant  <= pick.id;
                        AXI_ARADDR  <= pick.addr;
                        AXI_ARPROT  <= (pick.id == GRANT_I) ? 3'b100 : 3'b000;
                        AXI_ARCACHE <= 4'b0110;
                        AXI_ARVALID <= 1'b1;
                        state       <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    if (AXI_ARREADY) begin
                        AXI_ARVALID <= 1'b0;
                        AXI_RREADY  <= 1'b1;
                        cnt         <= '0;
                        err         <= 1'b0;
                        state       <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (beat) begin
                        if (cnt != CW'(N_WORD)) cnt <= cnt + CW'(1);
                        err <= err_next;
                        if (AXI_RLAST) begin
                            AXI_RREADY <= 1'b0;
                            LINE_ERR   <= err_next;
                            if (gnt_id == GRANT_I) I_VALID <= 1'b1;
                            else                   D_VALID <= 1'b1;
                            state      <= S_DONE;
                        end
                    end
                end
                S_DONE: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cache_refill_arbiter.sv
// Directed bench for cache_refill_arbiter: table of refill transactions plus a
// mid-burst reset sequence, with a behavioural AXI read slave.

module tb_cache_refill_arbiter;
    localparam int WIDTH_ADD = 32;
    localparam int DATA      = 32;
    localparam int N_WORD    = 8;

    logic                   AXI_CLK = 1'b0;
    logic                   AXI_RESETn;
    logic                   I_REQ, D_REQ;
    logic [WIDTH_ADD-1:0]   I_ADDR, D_ADDR;
    logic                   I_VALID, D_VALID;
    logic [DATA*N_WORD-1:0] LINE_DATA;
    logic                   LINE_ERR;
    logic                   AXI_ARVALID, AXI_ARREADY;
    logic [WIDTH_ADD-1:0]   AXI_ARADDR;
    logic [7:0]             AXI_ARLEN;
    logic [2:0]             AXI_ARSIZE;
    logic [1:0]             AXI_ARBURST;
    logic [2:0]             AXI_ARPROT;
    logic [3:0]             AXI_ARCACHE;
    logic                   AXI_RVALID;
    logic [DATA-1:0]        AXI_RDATA;
    logic [1:0]             AXI_RRESP;
    logic                   AXI_RLAST;
    logic                   AXI_RREADY;

    cache_refill_arbiter #(.WIDTH_ADD(WIDTH_ADD), .DATA(DATA), .N_WORD(N_WORD)) dut (
        .AXI_CLK(AXI_CLK), .AXI_RESETn(AXI_RESETn),
        .I_REQ(I_REQ), .I_ADDR(I_ADDR), .I_VALID(I_VALID),
        .D_REQ(D_REQ), .D_ADDR(D_ADDR), .D_VALID(D_VALID),
        .LINE_DATA(LINE_DATA), .LINE_ERR(LINE_ERR),
        .AXI_ARVALID(AXI_ARVALID), .AXI_ARREADY(AXI_ARREADY), .AXI_ARADDR(AXI_ARADDR),
        .AXI_ARLEN(AXI_ARLEN), .AXI_ARSIZE(AXI_ARSIZE), .AXI_ARBURST(AXI_ARBURST),
        .AXI_ARPROT(AXI_ARPROT), .AXI_ARCACHE(AXI_ARCACHE),
        .AXI_RVALID(AXI_RVALID), .AXI_RDATA(AXI_RDATA), .AXI_RRESP(AXI_RRESP),
        .AXI_RLAST(AXI_RLAST), .AXI_RREADY(AXI_RREADY)
    );

    always #5 AXI_CLK = ~AXI_CLK;

    typedef struct {
        logic        i_req;
        logic        d_req;
        logic [31:0] i_addr;
        logic [31:0] d_addr;
        int          ar_delay;
        int          nbeats;
        int          err_beat;
        logic        gap;
        logic [31:0] base;
        logic [31:0] exp_araddr;
        logic [2:0]  exp_prot;
        logic        exp_i;
        logic        exp_err;
    } vec_t;

    vec_t vecs[8];
    int   checks = 0;
    int   failures = 0;
    int   overlap = 0;
    logic [N_WORD-1:0][DATA-1:0] exp_line;

    always @(negedge AXI_CLK) if (AXI_ARVALID && AXI_RREADY) overlap++;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge AXI_CLK);
        #1;
    endtask

    task automatic run_vec(input vec_t v);
        int   n;
        logic stable;
        logic quiet;
        logic rdy_ok;
        I_REQ = v.i_req; D_REQ = v.d_req;
        I_ADDR = v.i_addr; D_ADDR = v.d_addr;
        AXI_ARREADY = 1'b0;
        n = 0;
        while (!AXI_ARVALID && n < 20) begin
            step();
            n++;
        end
        if (n >= 20) begin
            chk("arvalid_timeout", 0, 1);
            return;
        end
        chk("ar_latency", n, 1);
        chk("araddr", AXI_ARADDR, v.exp_araddr);
        chk("arprot", AXI_ARPROT, v.exp_prot);
        chk("arcache", AXI_ARCACHE, 4'b0110);
        chk("arlen", AXI_ARLEN, 8'd7);
        chk("arsize", AXI_ARSIZE, 3'd2);
        chk("arburst", AXI_ARBURST, 2'b01);
        I_ADDR = ~v.i_addr; D_ADDR = ~v.d_addr;
        stable = 1'b1;
        for (int d = 0; d < v.ar_delay; d++) begin
            step();
            if (!AXI_ARVALID || AXI_ARADDR != v.exp_araddr) stable = 1'b0;
        end
        chk("ar_stable", stable, 1'b1);
        AXI_ARREADY = 1'b1;
        step();
        AXI_ARREADY = 1'b0;
        chk("arvalid_drop", AXI_ARVALID, 1'b0);
        chk("rready_up", AXI_RREADY, 1'b1);
        quiet = 1'b1;
        rdy_ok = 1'b1;
        for (int b = 0; b < v.nbeats; b++) begin
            if (v.gap && b > 0) begin
                AXI_RVALID = 1'b0;
                AXI_RLAST = 1'b0;
                step();
                if (I_VALID || D_VALID) quiet = 1'b0;
            end
            AXI_RVALID = 1'b1;
            AXI_RDATA  = v.base + b;
            AXI_RRESP  = (b == v.err_beat) ? 2'b10 : 2'b00;
            AXI_RLAST  = (b == v.nbeats - 1);
            if (!AXI_RREADY) rdy_ok = 1'b0;
            if (I_VALID || D_VALID) quiet = 1'b0;
            if (b < N_WORD) exp_line[b] = v.base + b;
            step();
        end
        AXI_RVALID = 1'b0; AXI_RLAST = 1'b0; AXI_RRESP = 2'b00;
        chk("no_early_valid", quiet, 1'b1);
        chk("rready_held", rdy_ok, 1'b1);
        chk("i_valid", I_VALID, v.exp_i);
        chk("d_valid", D_VALID, !v.exp_i);
        chk("line_err", LINE_ERR, v.exp_err);
        chk("line_data", LINE_DATA, exp_line);
        chk("rready_drop", AXI_RREADY, 1'b0);
        step();
        chk("valid_one_cycle", {I_VALID, D_VALID}, 2'b00);
        if (v.exp_i) I_REQ = 1'b0;
        else         D_REQ = 1'b0;
    endtask

    initial begin
        //            i_req d_req i_addr        d_addr        dly nb err  gap base      araddr        prot    exp_i exp_err
        vecs[0] = '{1'b1, 1'b1, 32'h0000_1234, 32'h0000_3077, 0, 8, -1, 1'b0, 32'h100, 32'h0000_1220, 3'b100, 1'b1, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 32'h0000_0000, 32'h0000_3077, 0, 8, -1, 1'b0, 32'h200, 32'h0000_3060, 3'b000, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 1'b1, 32'h4000_001F, 32'h0000_3077, 0, 8, -1, 1'b0, 32'h300, 32'h4000_0000, 3'b100, 1'b1, 1'b0};
        vecs[3] = '{1'b1, 1'b1, 32'h1111_1111, 32'h5555_5555, 5, 8, -1, 1'b0, 32'h400, 32'h5555_5540, 3'b000, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 1'b0, 32'h0000_0FFF, 32'h0000_0000, 0, 8,  3, 1'b1, 32'h500, 32'h0000_0FE0, 3'b100, 1'b1, 1'b1};
        vecs[5] = '{1'b0, 1'b1, 32'h0000_0000, 32'h0000_8000, 0, 5, -1, 1'b0, 32'h600, 32'h0000_8000, 3'b000, 1'b0, 1'b1};
        vecs[6] = '{1'b1, 1'b0, 32'h0000_9010, 32'h0000_0000, 0, 10, -1, 1'b0, 32'h700, 32'h0000_9000, 3'b100, 1'b1, 1'b1};
        vecs[7] = '{1'b0, 1'b1, 32'h0000_0000, 32'hA0A0_A0BC, 2, 8, -1, 1'b0, 32'h900, 32'hA0A0_A0A0, 3'b000, 1'b0, 1'b0};

        AXI_RESETn = 1'b0;
        I_REQ = 1'b0; D_REQ = 1'b0; I_ADDR = '0; D_ADDR = '0;
        AXI_ARREADY = 1'b0; AXI_RVALID = 1'b0; AXI_RDATA = '0; AXI_RRESP = 2'b00; AXI_RLAST = 1'b0;
        exp_line = '0;
        step();
        step();
        chk("rst_arvalid", AXI_ARVALID, 1'b0);
        chk("rst_rready", AXI_RREADY, 1'b0);
        chk("rst_valids", {I_VALID, D_VALID, LINE_ERR}, 3'b000);
        chk("rst_line", LINE_DATA, '0);
        chk("rst_araddr", {AXI_ARADDR, AXI_ARPROT, AXI_ARCACHE}, '0);
        AXI_RESETn = 1'b1;
        step();
        chk("idle_arvalid", AXI_ARVALID, 1'b0);

        for (int k = 0; k < 7; k++) run_vec(vecs[k]);

        // Reset lands in the middle of a D burst, while beat 3 is on the bus.
        D_REQ = 1'b1; D_ADDR = 32'h0000_A000; I_REQ = 1'b0;
        step();
        chk("mr_arvalid", AXI_ARVALID, 1'b1);
        AXI_ARREADY = 1'b1;
        step();
        AXI_ARREADY = 1'b0;
        for (int b = 0; b < 3; b++) begin
            AXI_RVALID = 1'b1; AXI_RDATA = 32'hC00 + b; AXI_RLAST = 1'b0;
            step();
        end
        AXI_RDATA = 32'hBAD;
        #2;
        AXI_RESETn = 1'b0;
        #1;
        chk("mr_arvalid_zero", AXI_ARVALID, 1'b0);
        chk("mr_rready_zero", AXI_RREADY, 1'b0);
        chk("mr_valids_zero", {I_VALID, D_VALID, LINE_ERR}, 3'b000);
        chk("mr_line_zero", LINE_DATA, '0);
        chk("mr_addr_zero", {AXI_ARADDR, AXI_ARPROT, AXI_ARCACHE}, '0);
        AXI_RVALID = 1'b0; D_REQ = 1'b0;
        exp_line = '0;
        step();
        step();
        AXI_RESETn = 1'b1;
        step();
        chk("mr_idle", {AXI_ARVALID, AXI_RREADY}, 2'b00);
        run_vec(vecs[7]);

        chk("arvalid_rready_overlap", overlap, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end
endmodule

// File: doc/cache_refill_arbiter.md
Name: cache_refill_arbiter

Overview:
- Shares the single AXI read-address/read-data path between the I-cache and D-cache line-refill requests.
- Round-robin arbitration; issues one INCR burst of N_WORD beats per grant.
- Assembles the beats into a full cache line and returns it to the granted cache with a one-cycle valid pulse.
- Sits between both cache AXI front-ends and the system AXI interconnect.

Parameters:
WIDTH_ADD, 32, address width
DATA, 32, AXI data width (bits per beat, power of 2, ≥8)
N_WORD, 8, words per cache line (power of 2, 2..256)

Ports:
AXI_CLK  in  1  clock
AXI_RESETn  in  1  reset, asynchronous, active-low
I_REQ  in  1  I-cache refill request, level, held until I_VALID
I_ADDR  in  WIDTH_ADD  I-cache miss address
I_VALID  out  1  one-cycle pulse, LINE_DATA/LINE_ERR valid for I-cache
D_REQ  in  1  D-cache refill request, level, held until D_VALID
D_ADDR  in  WIDTH_ADD  D-cache miss address
D_VALID  out  1  one-cycle pulse, LINE_DATA/LINE_ERR valid for D-cache
LINE_DATA  out  DATA*N_WORD  assembled line, word 0 at LSBs
LINE_ERR  out  1  line error flag, qualified by I_VALID/D_VALID
AXI_ARVALID  out  1  read address valid
AXI_ARREADY  in  1  read address ready
AXI_ARADDR  out  WIDTH_ADD  line-aligned burst address
AXI_ARLEN  out  8  burst length, N_WORD-1
AXI_ARSIZE  out  3  log2(DATA/8)
AXI_ARBURST  out  2  2'b01 (INCR)
AXI_ARPROT  out  3  3'b100 for I grant, 3'b000 for D grant
AXI_ARCACHE  out  4  4'b0110
AXI_RVALID  in  1  read data valid
AXI_RDATA  in  DATA  read data
AXI_RRESP  in  2  read response
AXI_RLAST  in  1  last beat
AXI_RREADY  out  1  read data ready

Behaviour:
- Reset values: all outputs 0, FSM IDLE, beat counter 0, last_grant = D (I wins first tie). AXI_ARLEN, AXI_ARSIZE and AXI_ARBURST are constants.
- Mid-operation reset: immediate return to IDLE with all outputs 0; the in-flight burst is abandoned and not tracked.
- FSM states: IDLE, ADDR, DATA, DONE.
- IDLE:
  - Only one request: grant it.
  - Both requests: grant the one not equal to last_grant.
  - On grant: latch grant id and address. ARADDR = address with the low log2(N_WORD*DATA/8) bits cleared (bits 4:0 at defaults). Set last_grant and go to ADDR.
  - ARVALID rises in the cycle after the request is sampled.
- ADDR:
  - AXI_ARVALID=1; ARADDR/ARPROT/ARCACHE held stable until AXI_ARREADY.
  - On the ARVALID&ARREADY edge: ARVALID drops next cycle; go to DATA; beat counter=0; error accumulator=0.
- DATA:
  - AXI_RREADY=1.
  - Each RVALID beat with counter<N_WORD: RDATA written to word[counter], counter+1.
  - Any beat with RRESP≠2'b00 sets the error accumulator.
  - RLAST on beat counter==N_WORD-1: go to DONE.
  - Early RLAST (counter<N_WORD-1): set error, go to DONE. Unwritten words keep their previous contents.
  - Beats past N_WORD without RLAST: data dropped, error set, stay in DATA until RLAST.
- DONE (one cycle):
  - Pulse the granted requester's VALID for exactly one cycle.
  - LINE_DATA and LINE_ERR are driven from the line register and are stable during the pulse.
  - Go to IDLE.
- Refill latency: line valid exactly one cycle after the RLAST handshake.
- Requester contract: REQ deasserts the cycle after VALID. I_ADDR/D_ADDR changes after grant are ignored.
- Only one burst outstanding at any time; AXI_ARVALID and AXI_RREADY are never both 1.
- The non-granted requester waits; no request is lost.
- Simultaneous events: REQ arriving during ADDR/DATA/DONE is only sampled in IDLE. The arbitration decision uses last_grant as updated in the previous IDLE grant.

Test Plan:
- I_REQ alone, I_ADDR=0x0000_1234, ARREADY immediate, 8 beats RDATA=0x100+i, RLAST on beat 7 -> ARADDR=0x0000_1220, ARLEN=7, ARSIZE=2, ARBURST=1, ARPROT=3'b100; I_VALID 1 cycle after RLAST; LINE_DATA word i=0x100+i; LINE_ERR=0.
- I_REQ and D_REQ asserted in the same cycle after reset, both held -> I served first, then D (ARPROT=0), then I again if re-requested; D_VALID never pulses during an I burst.
- ARREADY held low for 5 cycles -> ARVALID stays 1 with stable ARADDR for those 5 cycles; transfer completes normally afterward.
- RRESP=2'b10 on beat 3 with RVALID gaps between beats -> all 8 words captured, LINE_ERR=1 with the VALID pulse.
- RLAST on beat 4 -> DONE immediately, LINE_ERR=1. Separately, 10 beats with RLAST on beat 9 -> words 0..7 kept, LINE_ERR=1, VALID after beat 9.
- AXI_RESETn asserted mid-DATA at beat 3 -> all outputs 0 the same cycle; after release, a fresh D_REQ completes a clean refill.
